// File: rtl/avalon_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : avalon_mem_arbiter
// Description : Shares one Avalon-MM master port between an instruction-fetch
//               requester (I) and a data load/store requester (D). One bus
//               transaction is in flight at a time. Bus fields are held stable
//               across waitrequest. Completion is reported with a one-cycle
//               done pulse and registered read data. A transaction that is
//               stalled too long is aborted and flagged with err.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TIMEOUT_CYCLES : consecutive waitrequest-high cycles before abort (1..65535)
// Ports
//   clk, reset     : rising-edge clock, synchronous active-high reset
//   i_req/i_addr   : fetch request (always a 32-bit read)
//   i_rdata/i_done : fetch read data, valid during the i_done pulse
//   d_req/d_we/d_addr/d_wdata/d_be : data request
//   d_rdata/d_done : data read data, valid during the d_done pulse
//   err            : pulses together with the done of an aborted transaction
//   address/read/write/writedata/byteenable/readdata/waitrequest : Avalon bus
// ============================================================================
module avalon_mem_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   // fetch port
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_done,
   // data port
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_be,
   output logic [31:0] d_rdata,
   output logic        d_done,
   output logic        err,
   // Avalon master
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic [31:0] readdata,
   input  logic        waitrequest
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   localparam logic [15:0] C_TIMEOUT = 16'(TIMEOUT_CYCLES);
   localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

   state_t      r_state;
   logic        r_last_d;     // 1 = D was granted last, 0 = I was granted last
   logic [15:0] r_wait_cnt;

   logic        w_elig_i;
   logic        w_elig_d;
   logic        w_grant_i;
   logic        w_grant_d;
   logic [15:0] w_cnt_inc;
   logic        w_timeout;

   // A request seen during its own done pulse is the tail of the transaction
   // that just finished, not a new one.
   assign w_elig_i = i_req & ~i_done;
   assign w_elig_d = d_req & ~d_done;

   // Round-robin on a tie: whoever was not granted last wins.
   assign w_grant_d = w_elig_d & (~w_elig_i | ~r_last_d);
   assign w_grant_i = w_elig_i & ~w_grant_d;

   // Saturating increment so the counter can never wrap back below the limit.
   assign w_cnt_inc = (r_wait_cnt == C_CNT_MAX) ? r_wait_cnt : (r_wait_cnt + 16'd1);
   assign w_timeout = (w_cnt_inc >= C_TIMEOUT);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_last_d   <= 1'b0;
         r_wait_cnt <= 16'd0;
         address    <= 32'd0;
         read       <= 1'b0;
         write      <= 1'b0;
         writedata  <= 32'd0;
         byteenable <= 4'd0;
         i_rdata    <= 32'd0;
         d_rdata    <= 32'd0;
         i_done     <= 1'b0;
         d_done     <= 1'b0;
         err        <= 1'b0;
      end else begin
         // done/err are single-cycle pulses
         i_done <= 1'b0;
         d_done <= 1'b0;
         err    <= 1'b0;

         case (r_state)
            IDLE: begin
               if (w_grant_d) begin
                  address    <= d_addr;
                  read       <= ~d_we;
                  write      <= d_we;
                  writedata  <= d_wdata;
                  byteenable <= d_be;
                  r_wait_cnt <= 16'd0;
                  r_last_d   <= 1'b1;
                  r_state    <= BUSY_D;
               end else if (w_grant_i) begin
                  address    <= i_addr;
                  read       <= 1'b1;
                  write      <= 1'b0;
                  byteenable <= 4'hF;
                  r_wait_cnt <= 16'd0;
                  r_last_d   <= 1'b0;
                  r_state    <= BUSY_I;
               end
            end

            BUSY_I, BUSY_D: begin
               if (waitrequest) begin
                  r_wait_cnt <= w_cnt_inc;
                  if (w_timeout) begin
                     // Abort: drop the strobe and report an empty result.
                     read    <= 1'b0;
                     write   <= 1'b0;
                     err     <= 1'b1;
                     r_state <= IDLE;
                     if (r_state == BUSY_I) begin
                        i_done  <= 1'b1;
                        i_rdata <= 32'd0;
                     end else begin
                        d_done  <= 1'b1;
                        d_rdata <= 32'd0;
                     end
                  end
               end else begin
                  read    <= 1'b0;
                  write   <= 1'b0;
                  r_state <= IDLE;
                  if (r_state == BUSY_I) begin
                     i_done <= 1'b1;
                     if (read) begin
                        i_rdata <= readdata;
                     end
                  end else begin
                     d_done <= 1'b1;
                     // Writes leave the previous read data in place.
                     if (read) begin
                        d_rdata <= readdata;
                     end
                  end
               end
            end

            default: begin
               read    <= 1'b0;
               write   <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_avalon_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_avalon_mem_arbiter
// Description : Scoreboard bench for avalon_mem_arbiter. Stimulus pushes the
//               expected bus transfers and done results into queues; a monitor
//               pops and compares whenever a strobe rises or a done pulses.
//               A small Avalon slave model with programmable wait states
//               backs the bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = 32'd0;
   logic [31:0] i_rdata;
   logic        i_done;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = 32'd0;
   logic [31:0] d_wdata = 32'd0;
   logic [3:0]  d_be = 4'd0;
   logic [31:0] d_rdata;
   logic        d_done;
   logic        err;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic [31:0] readdata;
   logic        waitrequest;

   always #5 clk = ~clk;

   avalon_mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .i_req      (i_req),
      .i_addr     (i_addr),
      .i_rdata    (i_rdata),
      .i_done     (i_done),
      .d_req      (d_req),
      .d_we       (d_we),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_be       (d_be),
      .d_rdata    (d_rdata),
      .d_done     (d_done),
      .err        (err),
      .address    (address),
      .read       (read),
      .write      (write),
      .writedata  (writedata),
      .byteenable (byteenable),
      .readdata   (readdata),
      .waitrequest(waitrequest)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- slave model ----------------
   int          wait_cycles = 0;
   logic        stuck = 1'b0;
   int          wcnt = 0;
   logic [31:0] mem [0:127];

   assign waitrequest = stuck || ((read || write) && (wcnt < wait_cycles));
   assign readdata    = mem[address[8:2]];

   always @(posedge clk) begin
      if (!(read || write)) wcnt <= 0;
      else if (waitrequest) wcnt <= wcnt + 1;
   end

   always @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < 128; k++) mem[k] <= 32'd0;
         mem[1] <= 32'h24020010;
         mem[2] <= 32'h11111111;
      end else if (write && !waitrequest) begin
         for (int b = 0; b < 4; b++)
            if (byteenable[b]) mem[address[8:2]][b*8 +: 8] <= writedata[b*8 +: 8];
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          dur;   // expected strobe cycles, 0 = not checked
      int          gap;   // expected idle cycles before strobe, -1 = not checked
   } bus_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } done_t;

   bus_t  bus_q[$];
   done_t exp_i[$];
   done_t exp_d[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic push_bus(input logic [31:0] a, input logic we, input logic [31:0] wd,
                           input logic [3:0] be, input int dur, input int gap);
      bus_t e;
      e.addr = a; e.we = we; e.wdata = wd; e.be = be; e.dur = dur; e.gap = gap;
      bus_q.push_back(e);
   endtask

   task automatic push_done(input bit is_d, input logic [31:0] rd, input logic er);
      done_t e;
      e.rdata = rd; e.err = er;
      if (is_d) exp_d.push_back(e);
      else      exp_i.push_back(e);
   endtask

   // ---------------- monitor ----------------
   bus_t        cap;
   logic        prev_strobe = 1'b0;
   int          dur_cnt = 0;
   int          gap_cnt = 0;

   always @(negedge clk) begin
      logic  strobe;
      bus_t  e;
      done_t de;
      strobe = read | write;

      if (strobe) chk("no_overlap", {31'd0, read & write}, 32'd0);

      if (strobe && !prev_strobe) begin
         if (bus_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_strobe: got addr %h expected no transfer", address);
         end else begin
            e = bus_q.pop_front();
            chk("bus_addr", address, e.addr);
            chk("bus_rw", {30'd0, read, write}, {30'd0, ~e.we, e.we});
            chk("bus_be", {28'd0, byteenable}, {28'd0, e.be});
            if (e.we) chk("bus_wdata", writedata, e.wdata);
            if (e.gap >= 0) chk("bus_gap", gap_cnt, e.gap);
            cap <= e;
         end
         dur_cnt <= 1;
      end else if (strobe && prev_strobe) begin
         chk("hold_addr", address, cap.addr);
         chk("hold_ctrl", {26'd0, read, write, byteenable}, {26'd0, ~cap.we, cap.we, cap.be});
         if (cap.we) chk("hold_wdata", writedata, cap.wdata);
         dur_cnt <= dur_cnt + 1;
      end else if (!strobe && prev_strobe) begin
         if (cap.dur > 0) chk("bus_dur", dur_cnt, cap.dur);
         gap_cnt <= 1;
      end else begin
         gap_cnt <= gap_cnt + 1;
      end

      if (i_done) begin
         chk("i_done_timing", {31'd0, prev_strobe & ~strobe}, 32'd1);
         if (exp_i.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_i_done: got i_done=1 expected 0");
         end else begin
            de = exp_i.pop_front();
            chk("i_rdata", i_rdata, de.rdata);
            chk("i_err", {31'd0, err}, {31'd0, de.err});
         end
      end
      if (d_done) begin
         chk("d_done_timing", {31'd0, prev_strobe & ~strobe}, 32'd1);
         if (exp_d.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_d_done: got d_done=1 expected 0");
         end else begin
            de = exp_d.pop_front();
            chk("d_rdata", d_rdata, de.rdata);
            chk("d_err", {31'd0, err}, {31'd0, de.err});
         end
      end
      if (err && !i_done && !d_done) begin
         checks++; errors++;
         $display("FAIL lone_err: got err=1 without done expected err=0");
      end

      prev_strobe <= strobe;
   end

   // ---------------- stimulus ----------------
   task automatic wait_done(input bit is_d, input int n);
      int seen = 0;
      for (int cyc = 0; cyc < 200 && seen < n; cyc++) begin
         @(negedge clk);
         if (is_d ? d_done : i_done) seen++;
      end
      if (seen < n) begin
         checks++; errors++;
         $display("FAIL %s_done_timeout: got %0d dones expected %0d", is_d ? "d" : "i", seen, n);
      end
   endtask

   task automatic issue_i(input logic [31:0] a);
      i_addr = a;
      i_req  = 1'b1;
      wait_done(1'b0, 1);
      i_req  = 1'b0;
   endtask

   task automatic issue_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be);
      d_we = we; d_addr = a; d_wdata = wd; d_be = be;
      d_req = 1'b1;
      wait_done(1'b1, 1);
      d_req = 1'b0;
   endtask

   initial begin
      int spins;
      repeat (3) @(negedge clk);
      // reset state
      chk("rst_strobes", {26'd0, read, write, byteenable}, 32'd0);
      chk("rst_address", address, 32'd0);
      chk("rst_writedata", writedata, 32'd0);
      chk("rst_pulses", {29'd0, i_done, d_done, err}, 32'd0);
      chk("rst_i_rdata", i_rdata, 32'd0);
      chk("rst_d_rdata", d_rdata, 32'd0);

      // simultaneous requests from reset release: D, I, D, I
      push_bus(32'h08, 1'b0, 32'h0, 4'hF, 1, -1);
      push_bus(32'h04, 1'b0, 32'h0, 4'hF, 1, 1);
      push_bus(32'h08, 1'b0, 32'h0, 4'hF, 1, 1);
      push_bus(32'h04, 1'b0, 32'h0, 4'hF, 1, 1);
      push_done(1'b1, 32'h11111111, 1'b0);
      push_done(1'b1, 32'h11111111, 1'b0);
      push_done(1'b0, 32'h24020010, 1'b0);
      push_done(1'b0, 32'h24020010, 1'b0);
      i_addr = 32'h04; d_addr = 32'h08; d_we = 1'b0; d_be = 4'hF;
      i_req = 1'b1; d_req = 1'b1; reset = 1'b0;
      fork
         begin wait_done(1'b0, 2); i_req = 1'b0; end
         begin wait_done(1'b1, 2); d_req = 1'b0; end
      join
      repeat (2) @(negedge clk);

      // single fetch
      push_bus(32'h04, 1'b0, 32'h0, 4'hF, 1, -1);
      push_done(1'b0, 32'h24020010, 1'b0);
      issue_i(32'h04);
      repeat (2) @(negedge clk);

      // data write with three wait states, then read it back
      wait_cycles = 3;
      push_bus(32'h100, 1'b1, 32'hA0, 4'h3, 4, -1);
      push_done(1'b1, 32'h11111111, 1'b0);
      issue_d(1'b1, 32'h100, 32'hA0, 4'h3);
      wait_cycles = 0;
      repeat (2) @(negedge clk);
      push_bus(32'h100, 1'b0, 32'h0, 4'hF, 1, -1);
      push_done(1'b1, 32'h000000A0, 1'b0);
      issue_d(1'b0, 32'h100, 32'h0, 4'hF);
      repeat (2) @(negedge clk);

      // timeout, then a normal fetch
      stuck = 1'b1;
      push_bus(32'h08, 1'b0, 32'h0, 4'hF, 4, -1);
      push_done(1'b0, 32'h0, 1'b1);
      issue_i(32'h08);
      stuck = 1'b0;
      push_bus(32'h04, 1'b0, 32'h0, 4'hF, 1, -1);
      push_done(1'b0, 32'h24020010, 1'b0);
      issue_i(32'h04);
      repeat (2) @(negedge clk);

      // request held through done: second fetch two idle cycles later
      push_bus(32'h08, 1'b0, 32'h0, 4'hF, 1, -1);
      push_bus(32'h08, 1'b0, 32'h0, 4'hF, 1, 2);
      push_done(1'b0, 32'h11111111, 1'b0);
      push_done(1'b0, 32'h11111111, 1'b0);
      i_addr = 32'h08; i_req = 1'b1;
      wait_done(1'b0, 2);
      i_req = 1'b0;
      repeat (2) @(negedge clk);

      // reset during a stalled data write
      stuck = 1'b1;
      push_bus(32'h0C, 1'b1, 32'h55, 4'hF, 0, -1);
      d_we = 1'b1; d_addr = 32'h0C; d_wdata = 32'h55; d_be = 4'hF; d_req = 1'b1;
      spins = 0;
      while (!write && spins < 20) begin @(negedge clk); spins++; end
      chk("mid_write_seen", {31'd0, write}, 32'd1);
      @(negedge clk);
      reset = 1'b1; d_req = 1'b0;
      @(negedge clk);
      chk("mid_rst_strobes", {30'd0, read, write}, 32'd0);
      chk("mid_rst_pulses", {29'd0, i_done, d_done, err}, 32'd0);
      repeat (2) @(negedge clk);
      stuck = 1'b0;
      push_bus(32'h0C, 1'b0, 32'h0, 4'hF, 1, -1);
      push_bus(32'h04, 1'b0, 32'h0, 4'hF, 1, 1);
      push_done(1'b1, 32'h0, 1'b0);
      push_done(1'b0, 32'h24020010, 1'b0);
      d_we = 1'b0; d_addr = 32'h0C; i_addr = 32'h04;
      i_req = 1'b1; d_req = 1'b1; reset = 1'b0;
      fork
         begin wait_done(1'b0, 1); i_req = 1'b0; end
         begin wait_done(1'b1, 1); d_req = 1'b0; end
      join

      repeat (5) @(negedge clk);
      chk("bus_q_empty", bus_q.size(), 32'd0);
      chk("exp_i_empty", exp_i.size(), 32'd0);
      chk("exp_d_empty", exp_d.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
